uart_tx_periph: RTL and testbench
=================================

UART_TX_PERIPH -- requirements
Module: uart_tx_periph

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line rate; DIV = CLK_HZ/BAUD (integer, truncated, DIV >= 2).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, power of two, number of byte entries.
REQ-004 SHALL have port clk, input, 1, clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port wr, input, 1, bus write strobe, single cycle.
REQ-007 SHALL have port rd, input, 1, bus read strobe.
REQ-008 SHALL have port addr, input, 32, byte address.
REQ-009 SHALL have port wdata, input, 32, write data.
REQ-010 SHALL have port rdata, output, 32, read data.
REQ-011 SHALL have port tx, output, 1, serial line, idle high.
REQ-012 SHALL have port irq, output, 1, level interrupt request.

Function
REQ-013 SHALL decode TXD at 0x4000_0018: a write pushes wdata[7:0] into the FIFO.
REQ-014 SHALL decode STATUS at 0x4000_0020 (read-only) as: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 irq_pend, bit4 overflow, bits[11:8] FIFO count, other bits 0.
REQ-015 SHALL decode CTRL at 0x4000_0024: bit0 irq_en is read/write; writing 1 to bit1 clears irq_pend; writing 1 to bit2 clears overflow; bits 1 and 2 read as 0.
REQ-016 SHALL drive rdata combinationally to the addressed register value when rd=1 and the address matches, and to 0 otherwise; writes to unmapped addresses SHALL be ignored.
REQ-017 SHALL drop a TXD write that arrives while the FIFO is full and no pop occurs in that cycle, and SHALL set overflow (sticky).
REQ-018 SHALL accept a TXD write to a full FIFO when a pop occurs in the same cycle.
REQ-019 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-020 In IDLE with the FIFO non-empty, the FSM SHALL, at the next edge, pop a byte into the shift register and enter START; tx SHALL go low from that edge.
REQ-021 SHALL hold each bit for exactly DIV clocks, using a baud counter that runs 0..DIV-1 and restarts at every state entry.
REQ-022 SHALL send DATA LSB first, 8 bits, with a 3-bit bit index that wraps 7->0 on the exit to the next state.
REQ-023 SHALL hold tx=1 for DIV clocks in STOP, then enter START directly if the FIFO is non-empty (no idle gap), else IDLE.
REQ-024 SHALL set irq_pend on the cycle STOP ends with the FIFO empty; a clear in the same cycle SHALL lose to the set.
REQ-025 SHALL drive irq = irq_pend AND irq_en.

Reset
REQ-026 On reset, SHALL immediately force tx=1, irq=0, state IDLE, FIFO empty, irq_en=0, irq_pend=0, overflow=0, and counters 0, aborting any frame in progress.

Configuration
REQ-027 With UART_TX_PARITY_EN defined, SHALL insert the PARITY state after DATA, sending even parity (XOR of the 8 data bits) for DIV clocks, giving an 11-bit frame.
REQ-028 Without UART_TX_PARITY_EN, DATA SHALL go directly to STOP, giving a 10-bit frame, and the PARITY state SHALL be absent.

Structure
REQ-029 SHALL place the register addresses, STATUS/CTRL bit positions, and the FSM state encoding in the shared package uart_tx_pkg.
REQ-030 SHALL implement the FIFO as the sub-module uart_tx_fifo, a synchronous FIFO with push, pop, full, empty, and count, DEPTH-parameterised, with wrapping pointers.

Verification (CLK_HZ=1000, BAUD=100, DIV=10)
REQ-031 Reset, then write 0x55 to TXD -> tx low 1 cycle later for 10 clocks, then 1,0,1,0,1,0,1,0, then high; STOP ends 100 clocks after START entry (110 with parity).
REQ-032 Set irq_en=1 and push 0xA3, 0x0F back-to-back -> two frames with no idle gap; irq rises only after the second STOP; a CTRL write of 0x3 drops irq.
REQ-033 Push 9 bytes in 9 consecutive cycles while busy -> status overflow=1 and count=8; a CTRL write of 0x4 clears overflow.
REQ-034 Full FIFO, TXD write in the same cycle as the pop at STOP end -> byte accepted, overflow stays 0.
REQ-035 Assert reset mid-DATA -> tx=1 in the same cycle, STATUS reads 0x002 after release.
REQ-036 With UART_TX_PARITY_EN, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_pkg
// Description : Shared definitions for the UART transmit peripheral:
//               register addresses, STATUS/CTRL bit positions and the
//               transmit FSM state encoding.
// Config      : UART_TX_PARITY_EN adds the PARITY state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    // Register map (full 32-bit byte-address decode)
    localparam logic [31:0] c_addr_txd    = 32'h4000_0018;
    localparam logic [31:0] c_addr_status = 32'h4000_0020;
    localparam logic [31:0] c_addr_ctrl   = 32'h4000_0024;

    // STATUS bit positions
    localparam int c_stat_full    = 0;
    localparam int c_stat_empty   = 1;
    localparam int c_stat_busy    = 2;
    localparam int c_stat_irq     = 3;
    localparam int c_stat_ovf     = 4;
    localparam int c_stat_cnt_lsb = 8;
    localparam int c_stat_cnt_w   = 4;

    // CTRL bit positions
    localparam int c_ctrl_irq_en  = 0;
    localparam int c_ctrl_irq_clr = 1;
    localparam int c_ctrl_ovf_clr = 2;

    // Transmit FSM state encoding
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_st_parity = 3'd3;
`endif
    localparam logic [2:0] c_st_stop   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Synchronous FIFO with show-ahead read data. Pointers wrap
//               naturally, so DEPTH must be a power of two (>= 2). A push
//               while full is only taken when a pop happens in the same cycle.
// Ports       : clk, reset (async, active-high)
//               push/din   - write one entry
//               pop/dout   - dout is the head entry; pop discards it
//               full, empty, count - occupancy flags and entry count
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];

    assign w_do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the slot being written.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; empty/count gate its visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_periph.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_periph
// Description : Memory-mapped UART transmitter with byte FIFO and level IRQ.
//               TXD    (0x4000_0018, WO) : push wdata[7:0]
//               STATUS (0x4000_0020, RO) : full, empty, busy, irq_pend,
//                                          overflow, count[11:8]
//               CTRL   (0x4000_0024)     : bit0 irq_en (RW), bit1 W1C
//                                          irq_pend, bit2 W1C overflow
// Ports       : clk, reset (async, active-high)
//               wr, rd, addr, wdata, rdata - simple bus slave
//               tx  - serial line, idle high
//               irq - irq_pend AND irq_en
// Config      : define UART_TX_PARITY_EN for an even-parity bit (11-bit
//               frame); default is 8N1 (10-bit frame).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_periph
    import uart_tx_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic        rd,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        irq
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_st_after_data = c_st_parity;
`else
    localparam logic [2:0] c_st_after_data = c_st_stop;
`endif

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic        w_sel_txd;
    logic        w_sel_status;
    logic        w_sel_ctrl;
    logic        w_wr_txd;
    logic        w_wr_ctrl;
    logic        w_unused_wdata;

    assign w_sel_txd      = (addr == c_addr_txd);
    assign w_sel_status   = (addr == c_addr_status);
    assign w_sel_ctrl     = (addr == c_addr_ctrl);
    assign w_wr_txd       = wr && w_sel_txd;
    assign w_wr_ctrl      = wr && w_sel_ctrl;
    assign w_unused_wdata = ^wdata[31:8];

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [7:0]    w_fifo_dout;
    logic [CW-1:0] w_count;
    logic [c_stat_cnt_w-1:0] w_count_nib;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_baud;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             w_baud_end;

    assign w_baud_end = (r_baud == CNT_W'(DIV - 1));

    // The FSM takes a byte when idle, or straight from the end of STOP so
    // back-to-back frames have no idle gap.
    assign w_pop  = !w_empty &&
                    ((r_state == c_st_idle) ||
                     ((r_state == c_st_stop) && w_baud_end));
    assign w_push = w_wr_txd && (!w_full || w_pop);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (wdata[7:0]),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Fit the FIFO count into the 4-bit STATUS field.
    generate
        if (CW >= c_stat_cnt_w) begin : g_cnt_trunc
            assign w_count_nib = w_count[c_stat_cnt_w-1:0];
        end else begin : g_cnt_ext
            assign w_count_nib = {{(c_stat_cnt_w-CW){1'b0}}, w_count};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
`ifdef UART_TX_PARITY_EN
    logic r_parity;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_baud <= '0;
                    if (w_pop) begin
                        r_state <= c_st_start;
                        r_shift <= w_fifo_dout;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^w_fifo_dout;
`endif
                    end
                end
                c_st_start: begin
                    if (w_baud_end) begin
                        r_state <= c_st_data;
                        r_baud  <= '0;
                    end else begin
                        r_baud  <= r_baud + CNT_W'(1);
                    end
                end
                c_st_data: begin
                    if (w_baud_end) begin
                        r_baud    <= '0;
                        r_shift   <= {1'b0, r_shift[7:1]};
                        // 3-bit index wraps 7 -> 0 on the exit edge.
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) r_state <= c_st_after_data;
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                c_st_parity: begin
                    if (w_baud_end) begin
                        r_state <= c_st_stop;
                        r_baud  <= '0;
                    end else begin
                        r_baud  <= r_baud + CNT_W'(1);
                    end
                end
`endif
                c_st_stop: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_state <= c_st_start;
                            r_shift <= w_fifo_dout;
`ifdef UART_TX_PARITY_EN
                            r_parity <= ^w_fifo_dout;
`endif
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_baud  <= '0;
                end
            endcase
        end
    end

    // Line driver decoded from registered state; IDLE after reset gives tx=1
    // immediately.
    always_comb begin
        tx = 1'b1;
        case (r_state)
            c_st_start:  tx = 1'b0;
            c_st_data:   tx = r_shift[0];
`ifdef UART_TX_PARITY_EN
            c_st_parity: tx = r_parity;
`endif
            default:     tx = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Control / interrupt state
    // ------------------------------------------------------------------
    logic r_irq_en;
    logic r_irq_pend;
    logic r_ovf;
    logic w_irq_set;
    logic w_ovf_set;

    assign w_irq_set = (r_state == c_st_stop) && w_baud_end && w_empty;
    assign w_ovf_set = w_wr_txd && w_full && !w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_en   <= 1'b0;
            r_irq_pend <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_irq_en <= wdata[c_ctrl_irq_en];
            // Set beats a same-cycle clear so an event is never lost.
            if (w_irq_set)
                r_irq_pend <= 1'b1;
            else if (w_wr_ctrl && wdata[c_ctrl_irq_clr])
                r_irq_pend <= 1'b0;
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (w_wr_ctrl && wdata[c_ctrl_ovf_clr])
                r_ovf <= 1'b0;
        end
    end

    assign irq = r_irq_pend & r_irq_en;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] w_status;

    always_comb begin
        w_status = '0;
        w_status[c_stat_full]  = w_full;
        w_status[c_stat_empty] = w_empty;
        w_status[c_stat_busy]  = (r_state != c_st_idle);
        w_status[c_stat_irq]   = r_irq_pend;
        w_status[c_stat_ovf]   = r_ovf;
        w_status[c_stat_cnt_lsb +: c_stat_cnt_w] = w_count_nib;
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (w_sel_status)
                rdata = w_status;
            else if (w_sel_ctrl)
                rdata[c_ctrl_irq_en] = r_irq_en;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_periph.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_periph
// Description : Self-checking bench for uart_tx_periph (CLK_HZ=1000,
//               BAUD=100, DIV=10). Register vectors from a table, serial
//               frames checked by a line monitor against a byte queue, plus
//               hand-written timing/overflow/reset sequences.
// Config      : honours UART_TX_PARITY_EN (11-bit frames, parity checks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_periph;

    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 100;
    localparam int DIV    = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS  = 11;
`else
    localparam int NBITS  = 10;
`endif
    localparam int FRAME  = NBITS * DIV;

    localparam logic [31:0] ADDR_TXD    = 32'h4000_0018;
    localparam logic [31:0] ADDR_STATUS = 32'h4000_0020;
    localparam logic [31:0] ADDR_CTRL   = 32'h4000_0024;

    localparam int OP_WR   = 0;
    localparam int OP_RD   = 1;
    localparam int OP_PEEK = 2;

    logic        clk;
    logic        reset;
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q [$];

    uart_tx_periph #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .wr    (wr),
        .rd    (rd),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .tx    (tx),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Tasks start just after a rising edge; a write takes effect on the next edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input bit accept);
        wr = 1'b1; addr = a; wdata = d;
        if (a == ADDR_TXD && accept) exp_q.push_back(d[7:0]);
        @(posedge clk); #1;
        wr = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        rd = 1'b1; addr = a;
        #1;
        d = rdata;
        rd = 1'b0; addr = '0;
    endtask

    task automatic wait_idle(input int budget);
        logic [31:0] s;
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            bus_read(ADDR_STATUS, s);
            if ((s & 32'h6) == 32'h2 && exp_q.size() == 0) done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("drain_done", {31'b0, done}, 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Line monitor: samples mid-bit, compares against the byte queue.
    // ------------------------------------------------------------------
    bit          mon_active = 1'b0;
    int          mon_cnt    = 0;
    int          mon_idx    = 0;
    logic [10:0] mon_bits   = '0;
    logic [7:0]  mon_exp    = '0;
    logic        last_parity = 1'b0;

    always @(negedge clk) begin
        if (reset) mon_active = 1'b0;
        else if (!mon_active) begin
            if (tx === 1'b0) begin mon_active = 1'b1; mon_cnt = 0; mon_bits = '0; end
        end else mon_cnt = mon_cnt + 1;
        if (mon_active && !reset && mon_cnt >= DIV/2 && ((mon_cnt - DIV/2) % DIV) == 0) begin
            mon_idx = (mon_cnt - DIV/2) / DIV;
            mon_bits[mon_idx] = tx;
            if (mon_idx == NBITS-1) begin
                mon_active = 1'b0;
                check("start_bit", {31'b0, mon_bits[0]}, 32'd0);
                check("stop_bit", {31'b0, mon_bits[NBITS-1]}, 32'd1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_frame: got byte 0x%02h expected no frame", mon_bits[8:1]);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("frame_byte", {24'b0, mon_bits[8:1]}, {24'b0, mon_exp});
`ifdef UART_TX_PARITY_EN
                    last_parity = mon_bits[9];
                    check("parity_bit", {31'b0, mon_bits[9]}, {31'b0, ^mon_exp});
`endif
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Register vector table
    // ------------------------------------------------------------------
    typedef struct {
        int          op;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic [31:0] r;
        logic [10:0] fb;
        logic [7:0]  b;

        vecs[0]  = '{OP_RD,   ADDR_STATUS,   32'h0,      32'h002};
        vecs[1]  = '{OP_RD,   ADDR_CTRL,     32'h0,      32'h000};
        vecs[2]  = '{OP_PEEK, ADDR_STATUS,   32'h0,      32'h000};
        vecs[3]  = '{OP_WR,   ADDR_CTRL,     32'h1,      32'h0};
        vecs[4]  = '{OP_RD,   ADDR_CTRL,     32'h0,      32'h001};
        vecs[5]  = '{OP_WR,   ADDR_CTRL,     32'h7,      32'h0};
        vecs[6]  = '{OP_RD,   ADDR_CTRL,     32'h0,      32'h001};
        vecs[7]  = '{OP_RD,   ADDR_STATUS,   32'h0,      32'h002};
        vecs[8]  = '{OP_RD,   ADDR_TXD,      32'h0,      32'h000};
        vecs[9]  = '{OP_WR,   32'h4000_001C, 32'hFF,     32'h0};
        vecs[10] = '{OP_RD,   32'h4000_0028, 32'h0,      32'h000};
        vecs[11] = '{OP_WR,   ADDR_STATUS,   32'hFFFF,   32'h0};
        vecs[12] = '{OP_RD,   ADDR_STATUS,   32'h0,      32'h002};
        vecs[13] = '{OP_WR,   ADDR_CTRL,     32'h0,      32'h0};
        vecs[14] = '{OP_RD,   ADDR_CTRL,     32'h0,      32'h000};
        vecs[15] = '{OP_RD,   32'h5000_0024, 32'h0,      32'h000};

        reset = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("tx_in_reset", {31'b0, tx}, 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("tx_after_reset", {31'b0, tx}, 32'd1);
        check("irq_after_reset", {31'b0, irq}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            case (vecs[i].op)
                OP_WR: bus_write(vecs[i].a, vecs[i].d, 1'b1);
                OP_RD: begin
                    bus_read(vecs[i].a, r);
                    check($sformatf("vec%0d_rdata", i), r, vecs[i].exp);
                end
                default: begin
                    rd = 1'b0; addr = vecs[i].a; #1;
                    check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp);
                    addr = '0;
                end
            endcase
        end
        @(posedge clk); #1;

        // ---- single frame 0x55: exact bit timing -------------------------
        b = 8'h55;
        fb = '1;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        fb[9] = ^b;
`endif
        bus_write(ADDR_TXD, {24'b0, b}, 1'b1);
        check("tx_before_start", {31'b0, tx}, 32'd1);
        for (int k = 0; k < FRAME; k++) begin
            @(posedge clk); #1;
            check($sformatf("f55_bit%0d", k / DIV), {31'b0, tx}, {31'b0, fb[k / DIV]});
        end
        bus_read(ADDR_STATUS, r);
        check("busy_last_stop_clk", r & 32'h4, 32'h4);
        @(posedge clk); #1;
        bus_read(ADDR_STATUS, r);
        check("status_after_f55", r, 32'h00A);
        check("irq_masked", {31'b0, irq}, 32'd0);
        bus_write(ADDR_CTRL, 32'h2, 1'b1);
        bus_read(ADDR_STATUS, r);
        check("status_irq_cleared", r, 32'h002);

        // ---- back-to-back frames, interrupt after the second ------------
        bus_write(ADDR_CTRL, 32'h1, 1'b1);
        bus_write(ADDR_TXD, 32'hA3, 1'b1);
        bus_write(ADDR_TXD, 32'h0F, 1'b1);
        for (int k = 0; k < 2*FRAME; k++) begin
            if (irq !== 1'b0) check("irq_early", {31'b0, irq}, 32'd0);
            if (k == FRAME-1) check("gap_stop", {31'b0, tx}, 32'd1);
            if (k == FRAME)   check("no_gap_start", {31'b0, tx}, 32'd0);
            @(posedge clk); #1;
        end
        check("irq_after_second", {31'b0, irq}, 32'd1);
        bus_write(ADDR_CTRL, 32'h3, 1'b1);
        check("irq_dropped", {31'b0, irq}, 32'd0);
        bus_read(ADDR_CTRL, r);
        check("irq_en_kept", r, 32'h1);
        bus_write(ADDR_CTRL, 32'h0, 1'b1);

        // ---- overflow: 9 pushes while busy ------------------------------
        bus_write(ADDR_TXD, 32'h11, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 0; i < 9; i++) bus_write(ADDR_TXD, 32'h20 + i, i < 8);
        bus_read(ADDR_STATUS, r);
        check("status_overflow", r, 32'h815);
        bus_write(ADDR_CTRL, 32'h4, 1'b1);
        bus_read(ADDR_STATUS, r);
        check("status_ovf_cleared", r, 32'h805);
        wait_idle(1500);
        bus_read(ADDR_STATUS, r);
        check("status_after_drain", r, 32'h00A);
        bus_write(ADDR_CTRL, 32'h2, 1'b1);

        // ---- write to full FIFO in the cycle of the STOP-end pop --------
        bus_write(ADDR_TXD, 32'h5A, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) bus_write(ADDR_TXD, 32'h30 + i, 1'b1);
        repeat (FRAME - 9) begin @(posedge clk); #1; end
        bus_read(ADDR_STATUS, r);
        check("full_before_pop", r, 32'h805);
        bus_write(ADDR_TXD, 32'h99, 1'b1);
        bus_read(ADDR_STATUS, r);
        check("full_push_on_pop", r, 32'h805);
        wait_idle(1500);
        bus_write(ADDR_CTRL, 32'h2, 1'b1);

        // ---- reset in the middle of DATA --------------------------------
        bus_write(ADDR_CTRL, 32'h1, 1'b1);
        bus_write(ADDR_TXD, 32'h00, 1'b1);
        bus_write(ADDR_TXD, 32'h12, 1'b1);
        bus_write(ADDR_TXD, 32'h34, 1'b1);
        repeat (28) begin @(posedge clk); #1; end
        check("tx_low_mid_data", {31'b0, tx}, 32'd0);
        reset = 1'b1;
        #1;
        check("tx_high_on_reset", {31'b0, tx}, 32'd1);
        check("irq_low_on_reset", {31'b0, irq}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        bus_read(ADDR_STATUS, r);
        check("status_after_abort", r, 32'h002);
        bus_read(ADDR_CTRL, r);
        check("ctrl_after_abort", r, 32'h0);
        bus_write(ADDR_TXD, 32'hC4, 1'b1);
        wait_idle(300);
        bus_write(ADDR_CTRL, 32'h2, 1'b1);

`ifdef UART_TX_PARITY_EN
        // ---- parity value checks ----------------------------------------
        bus_write(ADDR_TXD, 32'h07, 1'b1);
        wait_idle(300);
        check("parity_0x07", {31'b0, last_parity}, 32'd1);
        bus_write(ADDR_TXD, 32'h03, 1'b1);
        wait_idle(300);
        check("parity_0x03", {31'b0, last_parity}, 32'd0);
`endif

        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
